// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot sensor logic: FSM state codes,
// sensor pair codes and the default debounce length.
package parking_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_EN1      = 3'd1;
    localparam logic [2:0] ST_EN2      = 3'd2;
    localparam logic [2:0] ST_EN3      = 3'd3;
    localparam logic [2:0] ST_EX1      = 3'd4;
    localparam logic [2:0] ST_EX2      = 3'd5;
    localparam logic [2:0] ST_EX3      = 3'd6;
    localparam logic [2:0] ST_WAIT_CLR = 3'd7;

    // Sensor pair codes, ordered {a, b}.
    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_B    = 2'b01;
    localparam logic [1:0] P_A    = 2'b10;
    localparam logic [1:0] P_AB   = 2'b11;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit debounce filter: the output follows the input only after the
// input has differed from it for CYCLES consecutive clocks.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    // Any sample that agrees with the output restarts the count.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (din != out_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                out_d = din;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/car_direction_detector.sv
// Two-beam car direction detector producing entry/exit/error pulses.
// Optional build macro SENSOR_DEBOUNCE_EN inserts a debounce filter per sensor.
module car_direction_detector
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic seq_err,
    output logic busy
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("DEBOUNCE_CYCLES out of range 2..255");
    end

    // Bit 1 carries sensor a, bit 0 carries sensor b.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q[gi] <= 1'b0;
                sync2_q[gi] <= 1'b0;
            end else begin
                sync1_q[gi] <= (gi == 1) ? a : b;
                sync2_q[gi] <= sync1_q[gi];
            end
        end

`ifdef SENSOR_DEBOUNCE_EN
        sensor_debounce #(
            .CNT_W  (8),
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (sync2_q[gi]),
            .dout  (filt[gi])
        );
`else
        assign filt[gi] = sync2_q[gi];
`endif
    end

    logic [1:0] pair;
    logic [2:0] state_q, state_d;
    logic       inc_q, inc_d, dec_q, dec_d, err_q, err_d, busy_q, busy_d;

    assign pair = filt;

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        err_d   = 1'b0;
        // Every state accepts the pair it was entered on (hold), one forward
        // and one backward single-bit step; the remaining pair is a jump.
        case (state_q)
            ST_IDLE: begin
                case (pair)
                    P_A:     state_d = ST_EN1;
                    P_B:     state_d = ST_EX1;
                    P_AB:    begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_EN1: begin
                case (pair)
                    P_AB:    state_d = ST_EN2;
                    P_NONE:  state_d = ST_IDLE;
                    P_A:     state_d = ST_EN1;
                    default: begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                endcase
            end
            ST_EN2: begin
                case (pair)
                    P_B:     state_d = ST_EN3;
                    P_A:     state_d = ST_EN1;
                    P_AB:    state_d = ST_EN2;
                    default: begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                endcase
            end
            ST_EN3: begin
                case (pair)
                    P_NONE:  begin state_d = ST_IDLE; inc_d = 1'b1; end
                    P_AB:    state_d = ST_EN2;
                    P_B:     state_d = ST_EN3;
                    default: begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                endcase
            end
            ST_EX1: begin
                case (pair)
                    P_AB:    state_d = ST_EX2;
                    P_NONE:  state_d = ST_IDLE;
                    P_B:     state_d = ST_EX1;
                    default: begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                endcase
            end
            ST_EX2: begin
                case (pair)
                    P_A:     state_d = ST_EX3;
                    P_B:     state_d = ST_EX1;
                    P_AB:    state_d = ST_EX2;
                    default: begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                endcase
            end
            ST_EX3: begin
                case (pair)
                    P_NONE:  begin state_d = ST_IDLE; dec_d = 1'b1; end
                    P_AB:    state_d = ST_EX2;
                    P_A:     state_d = ST_EX3;
                    default: begin state_d = ST_WAIT_CLR; err_d = 1'b1; end
                endcase
            end
            ST_WAIT_CLR: begin
                if (pair == P_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign inc     = inc_q;
    assign dec     = dec_q;
    assign seq_err = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_car_direction_detector.sv
// Self-checking bench for car_direction_detector (default build, no debounce):
// directed scenarios followed by random sensor traffic against a path model.
module tb_car_direction_detector;

    logic clk = 1'b0;
    logic reset, a, b;
    logic inc, dec, seq_err, busy;

    int checks   = 0;
    int failures = 0;

    car_direction_detector dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .inc     (inc),
        .dec     (dec),
        .seq_err (seq_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a car walks along a 4-pair path (entry or exit);
    // mode 0 = idle, 1 = entry, 2 = exit, 3 = waiting for all-clear.
    logic [1:0] entry_path [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] exit_path  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         m_mode = 0;
    int         m_pos  = 0;
    logic [1:0] dly1 = 2'b00, dly2 = 2'b00;
    logic       e_inc, e_dec, e_err, e_busy;

    int cyc = 0;
    int inc_count = 0, dec_count = 0, err_count = 0;
    int last_inc_cyc = -1;
    int occupancy = 0;

    function automatic logic [1:0] path_at(input int mode, input int idx);
        return (mode == 1) ? entry_path[idx] : exit_path[idx];
    endfunction

    task automatic model_edge(input logic rst_now);
        logic [1:0] p;
        e_inc = 1'b0; e_dec = 1'b0; e_err = 1'b0;
        if (rst_now) begin
            m_mode = 0; m_pos = 0; dly1 = 2'b00; dly2 = 2'b00;
        end else begin
            // Two synchronizer stages between the pins and the decision.
            p    = dly2;
            dly2 = dly1;
            dly1 = {a, b};
            if (m_mode == 0) begin
                if (p == 2'b10)      begin m_mode = 1; m_pos = 1; end
                else if (p == 2'b01) begin m_mode = 2; m_pos = 1; end
                else if (p == 2'b11) begin m_mode = 3; e_err = 1'b1; end
            end else if (m_mode == 3) begin
                if (p == 2'b00) m_mode = 0;
            end else begin
                if (p == path_at(m_mode, m_pos)) begin
                    // no movement
                end else if (p == ((m_pos < 3) ? path_at(m_mode, m_pos + 1) : 2'b00)) begin
                    if (m_pos == 3) begin
                        if (m_mode == 1) e_inc = 1'b1; else e_dec = 1'b1;
                        m_mode = 0; m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end else if (p == path_at(m_mode, m_pos - 1)) begin
                    m_pos--;
                    if (m_pos == 0) m_mode = 0;
                end else begin
                    m_mode = 3; e_err = 1'b1;
                end
            end
        end
        e_busy = (m_mode != 0);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] p, input logic rst);
        a = p[1]; b = p[0]; reset = rst;
        @(posedge clk);
        cyc++;
        model_edge(rst);
        #1;
        check_bit("inc", inc, e_inc);
        check_bit("dec", dec, e_dec);
        check_bit("seq_err", seq_err, e_err);
        check_bit("busy", busy, e_busy);
        if (inc) begin inc_count++; occupancy++; last_inc_cyc = cyc; end
        if (dec) begin dec_count++; occupancy--; end
        if (seq_err) err_count++;
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) step(p, 1'b0);
    endtask

    initial begin
        int i0, d0, e0, apply_cyc;
        logic [1:0] cur;
        a = 1'b0; b = 1'b0; reset = 1'b1;

        for (int i = 0; i < 3; i++) step(2'b00, 1'b1);
        $display("reset: busy=%0b inc=%0b dec=%0b seq_err=%0b", busy, inc, dec, seq_err);
        hold(2'b00, 3);

        // Full entry, timing measured from when the final 00 is applied.
        i0 = inc_count; d0 = dec_count; e0 = err_count;
        hold(2'b00, 5); hold(2'b10, 5); hold(2'b11, 5); hold(2'b01, 5);
        apply_cyc = cyc;
        hold(2'b00, 5);
        check_int("entry_inc_count", inc_count - i0, 1);
        check_int("entry_dec_count", dec_count - d0, 0);
        check_int("entry_err_count", err_count - e0, 0);
        check_int("entry_latency", last_inc_cyc - apply_cyc, 3);
        $display("entry: inc pulses=%0d latency=%0d", inc_count - i0, last_inc_cyc - apply_cyc);

        // Three exits against an occupancy counter preloaded to 5.
        occupancy = 5; d0 = dec_count;
        for (int k = 0; k < 3; k++) begin
            hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 5);
        end
        check_int("exit_dec_count", dec_count - d0, 3);
        check_int("occupancy", occupancy, 2);
        $display("exits: dec pulses=%0d occupancy=%0d", dec_count - d0, occupancy);

        // Backtrack out of an entry.
        i0 = inc_count; d0 = dec_count; e0 = err_count;
        hold(2'b10, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 5);
        check_int("backtrack_pulses", (inc_count - i0) + (dec_count - d0) + (err_count - e0), 0);
        check_bit("backtrack_idle", busy, 1'b0);
        $display("backtrack: pulses=%0d busy=%0b", (inc_count - i0) + (dec_count - d0), busy);

        // Two-bit jump straight to 11.
        e0 = err_count; i0 = inc_count;
        hold(2'b11, 6);
        check_bit("jump_busy", busy, 1'b1);
        hold(2'b00, 5);
        check_int("jump_err_count", err_count - e0, 1);
        check_int("jump_inc_count", inc_count - i0, 0);
        check_bit("jump_cleared", busy, 1'b0);
        $display("jump: seq_err pulses=%0d busy=%0b", err_count - e0, busy);

        // Reset while at the last entry step, then 01 starts an exit.
        i0 = inc_count;
        hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
        step(2'b01, 1'b1); step(2'b01, 1'b1);
        hold(2'b01, 5);
        check_bit("post_reset_busy", busy, 1'b1);
        check_int("post_reset_inc", inc_count - i0, 0);
        hold(2'b00, 5);
        $display("reset mid-entry: inc pulses=%0d", inc_count - i0);

        // Random traffic: mostly single-bit moves, some jumps and resets.
        cur = 2'b00;
        for (int s = 0; s < 120; s++) begin
            int r, len;
            logic rst;
            r = int'($urandom_range(0, 99));
            if (r < 70)      cur = cur ^ ((($urandom_range(0, 1)) != 0) ? 2'b10 : 2'b01);
            else if (r < 80) cur = cur ^ 2'b11;
            else if (r < 95) cur = 2'b00;
            len = int'($urandom_range(1, 6));
            rst = ($urandom_range(0, 39) == 0);
            if (rst) step(cur, 1'b1);
            hold(cur, len);
            $display("random seg %0d: pair=%b len=%0d reset=%0b busy=%0b", s, cur, len, rst, busy);
        end
        hold(2'b00, 6);
        check_bit("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_direction_detector.md
CAR_DIRECTION_DETECTOR -- requirements
Module: car_direction_detector

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a sensor change is accepted (range 2..255; used only with SENSOR_DEBOUNCE_EN).
REQ-002 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: a  input  1  outer photo-sensor, 1 = beam blocked; asynchronous to clk.
REQ-005 Port: b  input  1  inner photo-sensor, 1 = beam blocked; asynchronous to clk.
REQ-006 Port: inc  output  1  one-cycle pulse, one car completed entry; connects directly to the occupancy counter inc.
REQ-007 Port: dec  output  1  one-cycle pulse, one car completed exit; connects directly to the occupancy counter dec.
REQ-008 Port: seq_err  output  1  one-cycle pulse, illegal sensor transition detected.
REQ-009 Port: busy  output  1  level, high whenever FSM is not in IDLE.

Function
REQ-010 a and b SHALL each pass through a 2-flop synchronizer; FSM SHALL act only on filtered values af/bf, sampled as pair {af,bf}.
REQ-011 FSM states SHALL be IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR.
REQ-012 Entry path: IDLE-10->EN1, EN1-11->EN2, EN2-01->EN3, EN3-00->IDLE with inc pulse.
REQ-013 Exit path: IDLE-01->EX1, EX1-11->EX2, EX2-10->EX3, EX3-00->IDLE with dec pulse.
REQ-014 Backtrack SHALL be legal with no pulse: EN1-00->IDLE, EN2-10->EN1, EN3-11->EN2, EX1-00->IDLE, EX2-01->EX1, EX3-11->EX2.
REQ-015 Unchanged {af,bf} SHALL hold current state.
REQ-016 Any other transition (two-bit jump, e.g. IDLE-11, EN1-01, EN3-10) SHALL go to WAIT_CLR with seq_err pulse, no inc/dec.
REQ-017 WAIT_CLR SHALL stay until {af,bf}=00, then go to IDLE, no pulse; no further seq_err while in WAIT_CLR.
REQ-018 inc/dec/seq_err SHALL be registered, high exactly one cycle, in the cycle after the edge where the triggering pair is sampled.
REQ-019 inc and dec SHALL never be high in the same cycle; seq_err SHALL never coincide with inc or dec.
REQ-020 busy SHALL be registered, derived from next state, i.e. equal to (state != IDLE) in the same cycle as any pulse.
REQ-021 Latency, macro off: sensor edge to inc/dec pulse = 3 cycles (2 sync + 1 output register).

Reset
REQ-022 On reset=1 at posedge clk: state IDLE; inc, dec, seq_err, busy = 0; synchronizer flops, af, bf = 0; debounce counters = 0.
REQ-023 Reset mid-sequence SHALL drop the sequence with no pulse; after release, a nonzero pair is treated per REQ-012..016 from IDLE (10->EN1, 01->EX1, 11->WAIT_CLR with seq_err).

Configuration
REQ-024 Macro SENSOR_DEBOUNCE_EN defined: each synchronized sensor SHALL feed a debounce filter; af/bf update only after the new value is stable DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count; latency = 3 + DEBOUNCE_CYCLES cycles.
REQ-025 Macro undefined: af/bf SHALL equal synchronizer outputs directly; DEBOUNCE_CYCLES ignored; no debounce logic synthesized.

Structure
REQ-026 Shared package parking_pkg SHALL hold state encoding constants (3-bit, 8 states) and default DEBOUNCE_CYCLES value, shared with the occupancy counter bench.
REQ-027 Debounce SHALL be one sub-module sensor_debounce (1-bit in, 1-bit out, width-of-count parameter), instantiated twice, only under SENSOR_DEBOUNCE_EN.

Verification
REQ-028 Macro off, pairs 00,10,11,01,00 each held 5 cycles -> one inc pulse exactly 3 cycles after final 00 applied; dec, seq_err stay 0.
REQ-029 Macro off, 00,01,11,10,00 -> one dec pulse; feed 3 such exits into counter preloaded to 5 -> occupancy 2.
REQ-030 Backtrack 10,11,10,00 -> no pulse, busy returns 0, state IDLE.
REQ-031 Jump 00->11 -> seq_err one cycle, busy stays 1 until 00 applied, then IDLE; no inc/dec.
REQ-032 Reset asserted while in EN3 (pair 01) -> no inc; after release with 01 held, FSM enters EX1, busy=1.
REQ-033 SENSOR_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle glitch on a -> no state change; full entry sequence -> inc 7 cycles after final 00.
